byte_encode_stream: RTL and testbench
=====================================

Name: byte_encode_stream

Overview:
- Sequential ByteEncode_d stage for the Kyber-768-90s datapath.
- Accepts one polynomial of 256 coefficients, each D bits wide, on a valid/ready stream.
- Concatenates the coefficients LSB-first into a bit stream and emits packed bytes on a second valid/ready stream.
- Sits between the compress/NTT-output logic and the byte-serialised ciphertext/key buffers.

Parameters:
- D, 12, bits per coefficient; legal values 1, 4, 10, 11, 12.
- N_COEFF, 256, coefficients per polynomial.
- N_BYTES, N_COEFF*D/8, bytes emitted per polynomial; derived, do not override.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start_i  in  1  begin a polynomial; sampled only in IDLE.
- coeff_i  in  D  coefficient; only bits [D-1:0] are used.
- coeff_valid_i  in  1  coeff_i valid.
- coeff_ready_o  out  1  encoder accepts coeff_i this cycle.
- byte_o  out  8  packed output byte.
- byte_valid_o  out  1  byte_o valid.
- byte_ready_i  in  1  downstream accepts byte_o.
- busy_o  out  1  high in RUN.
- done_o  out  1  one-cycle pulse after the last byte is accepted.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; accumulator, bit count, coefficient count and byte count cleared; all outputs 0. Reset mid-polynomial discards all partial data and emits no further bytes.
- Bit order: stream bit k = coefficient k/D, bit k%D. Stream bit k maps to byte_o of byte k/8, bit k%8 (little-endian bits, bytes in ascending order).
- Storage:
  - acc: D+7 bits.
  - cnt: valid bit count, 0..D+7.
  - ccnt: coefficients accepted, 0..256.
  - bcnt: bytes emitted, 0..N_BYTES.
- FSM IDLE:
  - All handshake outputs 0.
  - start_i=1 -> RUN; clears acc, cnt, ccnt, bcnt.
- FSM RUN:
  - busy_o=1.
  - coeff_ready_o = (cnt<8) && (ccnt<256). Registered-state function only; no combinational path from byte_ready_i or coeff_valid_i.
  - byte_valid_o = (cnt>=8). byte_o = acc[7:0].
  - Coefficient handshake (coeff_valid_i && coeff_ready_o): acc |= coeff_i[D-1:0] << cnt; cnt += D; ccnt++.
  - Byte handshake (byte_valid_o && byte_ready_i): acc >>= 8; cnt -= 8; bcnt++.
  - Both handshakes in the same cycle cannot occur, because ready requires cnt<8 and valid requires cnt>=8.
  - byte_o and byte_valid_o are held stable while byte_ready_i=0.
  - Last byte handshake (bcnt reaches N_BYTES, cnt returns to 0) -> DONE.
- FSM DONE:
  - done_o=1 for exactly one cycle, then -> IDLE.
  - start_i asserted in DONE is ignored.
- start_i in RUN or DONE is ignored.
- Coefficient values are not range-checked; upper input bits above D are dropped.
- Latency:
  - First byte_valid_o goes high the cycle after the coefficient handshake that brings cnt>=8.
  - done_o goes high the cycle after the final byte handshake.
- Throughput at D=12 with no backpressure: 3 bytes per 2 coefficients. The sequence is accept, emit, accept, emit, emit, i.e. 5 cycles per 2 coefficients.
- cnt never exceeds D+7, so acc never overflows.
- 256*D is a multiple of 8, so cnt=0 at completion.

Test Plan:
- D=12, start, coeff_i=0x123 then 0x456 -> bytes 0x23, 0x61, 0x45 in order. Full 256-coefficient frame gives 384 byte handshakes and exactly one done_o pulse, the cycle after byte 384.
- D=1, 256 coefficients alternating 1,0 (coeff 0 = 1) -> 32 bytes, all 0x55. D=4 with coefficients 0x1, 0x2 repeated -> 128 bytes, all 0x21.
- Backpressure, D=12: hold byte_ready_i=0 for 10 cycles after the first byte_valid_o -> byte_o stays 0x23 and coeff_ready_o stays 0. Releasing byte_ready_i resumes the stream with no byte lost or duplicated.
- D=10, random coefficient values with bits above [9:0] set, plus random gaps on coeff_valid_i and byte_ready_i -> output bytes match a scoreboard model of the packing that ignores the upper bits; 320 bytes total.
- Assert start_i during RUN and during DONE -> no counter clear, no restart; the frame completes normally.
- Pull rst_n low after 100 coefficients -> all outputs 0 asynchronously. After release, a fresh start_i with coeffs 0x123, 0x456 yields 0x23, 0x61, 0x45, with no stale bits from the aborted frame.

Source files
------------

// File: rtl/byte_encode_stream.sv
// byte_encode_stream: ByteEncode_d packer for one 256-coefficient polynomial.
// Coefficients of D bits are concatenated LSB-first into a bit stream and
// emitted as little-endian bytes, in ascending order.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start_i           begin a polynomial (sampled only in IDLE)
//   coeff_i           D-bit coefficient
//   coeff_valid_i     coeff_i valid
//   coeff_ready_o     encoder accepts coeff_i this cycle
//   byte_o            packed output byte
//   byte_valid_o      byte_o valid
//   byte_ready_i      downstream accepts byte_o
//   busy_o            high while a polynomial is in progress
//   done_o            one-cycle pulse after the last byte is accepted
module byte_encode_stream #(
  parameter int unsigned D       = 12,
  parameter int unsigned N_COEFF = 256
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_i,
  input  logic [D-1:0] coeff_i,
  input  logic         coeff_valid_i,
  output logic         coeff_ready_o,
  output logic [7:0]   byte_o,
  output logic         byte_valid_o,
  input  logic         byte_ready_i,
  output logic         busy_o,
  output logic         done_o
);

  localparam int unsigned N_BYTES = (N_COEFF * D) / 8;
  localparam int unsigned ACC_W   = D + 7;
  localparam int unsigned CNT_W   = $clog2(D + 8);
  localparam int unsigned CCNT_W  = $clog2(N_COEFF + 1);
  localparam int unsigned BCNT_W  = $clog2(N_BYTES + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state, state_n;
  logic [ACC_W-1:0]    acc, acc_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic [CCNT_W-1:0]   ccnt, ccnt_n;
  logic [BCNT_W-1:0]   bcnt, bcnt_n;

  logic                coeff_ready_n;
  logic [7:0]          byte_n;
  logic                byte_valid_n;
  logic                busy_n;
  logic                done_n;
  logic                coeff_take;
  logic                byte_take;

  // State, datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      acc           <= '0;
      cnt           <= '0;
      ccnt          <= '0;
      bcnt          <= '0;
      coeff_ready_o <= 1'b0;
      byte_o        <= 8'h00;
      byte_valid_o  <= 1'b0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
    end else begin
      state         <= state_n;
      acc           <= acc_n;
      cnt           <= cnt_n;
      ccnt          <= ccnt_n;
      bcnt          <= bcnt_n;
      coeff_ready_o <= coeff_ready_n;
      byte_o        <= byte_n;
      byte_valid_o  <= byte_valid_n;
      busy_o        <= busy_n;
      done_o        <= done_n;
    end
  end

  // Next-state, datapath update and next output values
  always_comb begin
    state_n    = state;
    acc_n      = acc;
    cnt_n      = cnt;
    ccnt_n     = ccnt;
    bcnt_n     = bcnt;
    coeff_take = 1'b0;
    byte_take  = 1'b0;

    unique case (state)
      IDLE: begin
        if (start_i) begin
          state_n = RUN;
          acc_n   = '0;
          cnt_n   = '0;
          ccnt_n  = '0;
          bcnt_n  = '0;
        end
      end

      RUN: begin
        // ready needs cnt<8 and valid needs cnt>=8, so at most one fires
        coeff_take = coeff_valid_i && coeff_ready_o;
        byte_take  = byte_valid_o && byte_ready_i;
        if (coeff_take) begin
          acc_n  = acc | (ACC_W'(coeff_i) << cnt);
          cnt_n  = cnt + CNT_W'(D);
          ccnt_n = ccnt + CCNT_W'(1);
        end else if (byte_take) begin
          acc_n  = acc >> 8;
          cnt_n  = cnt - CNT_W'(8);
          bcnt_n = bcnt + BCNT_W'(1);
          if (bcnt_n == BCNT_W'(N_BYTES)) begin
            state_n = DONE;
          end
        end
      end

      DONE: begin
        state_n = IDLE;
      end

      default: begin
        state_n = IDLE;
      end
    endcase

    // Outputs are registered copies of the functions of the next state
    coeff_ready_n = (state_n == RUN) && (cnt_n < CNT_W'(8)) &&
                    (ccnt_n < CCNT_W'(N_COEFF));
    byte_valid_n  = (state_n == RUN) && (cnt_n >= CNT_W'(8));
    byte_n        = (state_n == RUN) ? acc_n[7:0] : 8'h00;
    busy_n        = (state_n == RUN);
    done_n        = (state_n == DONE);
  end

endmodule

// File: tb/tb_byte_encode_stream.sv
// tb_byte_encode_stream: directed checks of byte_encode_stream at D=12, 1, 4, 10.
module tb_byte_encode_stream;

  logic        clk;
  logic        rst_n;

  logic        start_s  [4];
  logic        cvalid_s [4];
  logic        cready_s [4];
  logic [7:0]  bdata_s  [4];
  logic        bvalid_s [4];
  logic        bready_s [4];
  logic        busy_s   [4];
  logic        done_s   [4];

  logic [11:0] c12;
  logic [0:0]  c1;
  logic [3:0]  c4;
  logic [9:0]  c10;

  int          n_cmp;
  int          n_err;
  logic [15:0] coeff_q [$];
  logic [7:0]  exp_q   [$];
  logic [7:0]  obs_first [3];
  int          last_nbytes;

  byte_encode_stream #(.D(12)) u_d12 (
    .clk(clk), .rst_n(rst_n), .start_i(start_s[0]), .coeff_i(c12),
    .coeff_valid_i(cvalid_s[0]), .coeff_ready_o(cready_s[0]), .byte_o(bdata_s[0]),
    .byte_valid_o(bvalid_s[0]), .byte_ready_i(bready_s[0]), .busy_o(busy_s[0]),
    .done_o(done_s[0]));

  byte_encode_stream #(.D(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .start_i(start_s[1]), .coeff_i(c1),
    .coeff_valid_i(cvalid_s[1]), .coeff_ready_o(cready_s[1]), .byte_o(bdata_s[1]),
    .byte_valid_o(bvalid_s[1]), .byte_ready_i(bready_s[1]), .busy_o(busy_s[1]),
    .done_o(done_s[1]));

  byte_encode_stream #(.D(4)) u_d4 (
    .clk(clk), .rst_n(rst_n), .start_i(start_s[2]), .coeff_i(c4),
    .coeff_valid_i(cvalid_s[2]), .coeff_ready_o(cready_s[2]), .byte_o(bdata_s[2]),
    .byte_valid_o(bvalid_s[2]), .byte_ready_i(bready_s[2]), .busy_o(busy_s[2]),
    .done_o(done_s[2]));

  byte_encode_stream #(.D(10)) u_d10 (
    .clk(clk), .rst_n(rst_n), .start_i(start_s[3]), .coeff_i(c10),
    .coeff_valid_i(cvalid_s[3]), .coeff_ready_o(cready_s[3]), .byte_o(bdata_s[3]),
    .byte_valid_o(bvalid_s[3]), .byte_ready_i(bready_s[3]), .busy_o(busy_s[3]),
    .done_o(done_s[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int expv);
    n_cmp++;
    if (got != expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, expv);
    end
  endtask

  task automatic set_coeff(input int idx, input logic [15:0] v);
    case (idx)
      0:       c12 = v[11:0];
      1:       c1  = v[0:0];
      2:       c4  = v[3:0];
      default: c10 = v[9:0];
    endcase
  endtask

  // Bit-level reference: stream bit k = coeff k/d bit k%d, packed LSB-first
  task automatic build_exp(input int d);
    logic [15:0] v;
    logic [7:0]  b;
    int          nb;
    exp_q.delete();
    b  = 8'h00;
    nb = 0;
    for (int k = 0; k < coeff_q.size(); k++) begin
      v = coeff_q[k];
      for (int j = 0; j < d; j++) begin
        b[nb] = v[j];
        nb++;
        if (nb == 8) begin
          exp_q.push_back(b);
          b  = 8'h00;
          nb = 0;
        end
      end
    end
  endtask

  task automatic idle_drive(input int idx);
    start_s[idx]  = 1'b0;
    cvalid_s[idx] = 1'b0;
    bready_s[idx] = 1'b0;
    set_coeff(idx, 16'h0000);
  endtask

  // Stream one frame from coeff_q into instance idx, checking bytes against exp_q
  task automatic run_frame(input int idx, input int cgap, input int bgap,
                           input int hold_first, input bit glitch, input int abort_at);
    int ci;
    int bi;
    int cyc;
    int hold;
    int dones;
    ci = 0; bi = 0; cyc = 0; hold = hold_first; dones = 0;
    @(negedge clk);
    start_s[idx] = 1'b1;
    @(negedge clk);
    start_s[idx] = 1'b0;
    check("busy_after_start", busy_s[idx], 1);
    while (bi < exp_q.size() && cyc < 20000) begin
      cvalid_s[idx] = (ci < coeff_q.size()) && ($urandom_range(99) >= cgap);
      if (cvalid_s[idx]) set_coeff(idx, coeff_q[ci]);
      else               set_coeff(idx, 16'($urandom));
      bready_s[idx] = ($urandom_range(99) >= bgap);
      if (bvalid_s[idx] && hold > 0) begin
        bready_s[idx] = 1'b0;
        check("bp_byte_held", bdata_s[idx], 8'h23);
        check("bp_cready_low", cready_s[idx], 0);
        hold--;
      end
      start_s[idx] = glitch && (ci == 50);
      if (abort_at > 0 && ci == abort_at) begin
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy_s[idx], 0);
        check("abort_cready", cready_s[idx], 0);
        check("abort_bvalid", bvalid_s[idx], 0);
        check("abort_byte", bdata_s[idx], 0);
        check("abort_done", done_s[idx], 0);
        idle_drive(idx);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_stays_idle", busy_s[idx], 0);
        return;
      end
      if (done_s[idx]) dones++;
      if (cvalid_s[idx] && cready_s[idx]) ci++;
      if (bvalid_s[idx] && bready_s[idx]) begin
        check($sformatf("byte[%0d]", bi), bdata_s[idx], exp_q[bi]);
        if (bi < 3) obs_first[bi] = bdata_s[idx];
        bi++;
      end
      cyc++;
      @(negedge clk);
    end
    last_nbytes = bi;
    check("frame_timeout", (cyc < 20000) ? 1 : 0, 1);
    check("early_done", dones, 0);
    check("coeffs_consumed", ci, coeff_q.size());
    idle_drive(idx);
    check("done_pulse", done_s[idx], 1);
    check("busy_in_done", busy_s[idx], 0);
    check("bvalid_in_done", bvalid_s[idx], 0);
    if (glitch) start_s[idx] = 1'b1;
    @(negedge clk);
    start_s[idx] = 1'b0;
    check("done_one_cycle", done_s[idx], 0);
    check("idle_after_done", busy_s[idx], 0);
    @(negedge clk);
    check("no_restart", busy_s[idx], 0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    last_nbytes = 0;
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) idle_drive(i);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rst_busy%0d", i), busy_s[i], 0);
      check($sformatf("rst_cready%0d", i), cready_s[i], 0);
      check($sformatf("rst_bvalid%0d", i), bvalid_s[i], 0);
      check($sformatf("rst_done%0d", i), done_s[i], 0);
      check($sformatf("rst_byte%0d", i), bdata_s[i], 0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // D=12: 0x123, 0x456 lead a full frame; first byte held 10 cycles
    coeff_q.delete();
    coeff_q.push_back(16'h0123);
    coeff_q.push_back(16'h0456);
    for (int k = 2; k < 256; k++) coeff_q.push_back(16'($urandom_range(4095)));
    build_exp(12);
    run_frame(0, 0, 0, 10, 1'b0, 0);
    check("d12_b0", obs_first[0], 8'h23);
    check("d12_b1", obs_first[1], 8'h61);
    check("d12_b2", obs_first[2], 8'h45);
    check("d12_nbytes", last_nbytes, 384);

    // D=1: alternating 1,0 -> 32 bytes of 0x55
    coeff_q.delete();
    exp_q.delete();
    for (int k = 0; k < 256; k++) coeff_q.push_back((k % 2 == 0) ? 16'h0001 : 16'h0000);
    for (int k = 0; k < 32; k++) exp_q.push_back(8'h55);
    run_frame(1, 0, 0, 0, 1'b0, 0);
    check("d1_nbytes", last_nbytes, 32);

    // D=4: 0x1, 0x2 repeated -> 128 bytes of 0x21
    coeff_q.delete();
    exp_q.delete();
    for (int k = 0; k < 256; k++) coeff_q.push_back((k % 2 == 0) ? 16'h0001 : 16'h0002);
    for (int k = 0; k < 128; k++) exp_q.push_back(8'h21);
    run_frame(2, 0, 0, 0, 1'b0, 0);
    check("d4_nbytes", last_nbytes, 128);

    // D=10: random values with upper bits set, random gaps on both sides
    coeff_q.delete();
    for (int k = 0; k < 256; k++) coeff_q.push_back(16'($urandom) | 16'hFC00);
    build_exp(10);
    run_frame(3, 30, 30, 0, 1'b0, 0);
    check("d10_nbytes", last_nbytes, 320);

    // D=12: start_i pulsed mid-frame and in DONE must be ignored
    coeff_q.delete();
    for (int k = 0; k < 256; k++) coeff_q.push_back(16'($urandom_range(4095)));
    build_exp(12);
    run_frame(0, 20, 20, 0, 1'b1, 0);
    check("glitch_nbytes", last_nbytes, 384);

    // D=12: reset after 100 coefficients, then a clean frame
    run_frame(0, 0, 0, 0, 1'b0, 100);
    coeff_q.delete();
    coeff_q.push_back(16'h0123);
    coeff_q.push_back(16'h0456);
    for (int k = 2; k < 256; k++) coeff_q.push_back(16'($urandom_range(4095)));
    build_exp(12);
    run_frame(0, 10, 10, 0, 1'b0, 0);
    check("post_rst_b0", obs_first[0], 8'h23);
    check("post_rst_b1", obs_first[1], 8'h61);
    check("post_rst_b2", obs_first[2], 8'h45);
    check("post_rst_nbytes", last_nbytes, 384);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
